// File: rtl/clk_div_prog.sv
// clk_div_prog: multi-channel programmable clock divider with shadowed ratio updates and phase sync.
// Define CLK_DIV_ODD50_EN to add a falling-edge stage that gives odd ratios a 50% duty cycle.
module clk_div_prog #(
  parameter int CH       = 2,
  parameter int CNT_W    = 8,
  parameter int DIV_INIT = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_wr,
  input  logic [2:0]       div_ch,
  input  logic [CNT_W-1:0] div_val,
  input  logic             sync,
  output logic [CH-1:0]    clk_out,
  output logic [CH-1:0]    tick,
  output logic [CH-1:0]    upd_pend
);
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [CNT_W-1:0] n, s, cnt;
    logic ck, tk, pd, act, wrap, hit, apply;
    always_comb begin
      act   = n >= CNT_W'(2);
      wrap  = act && (sync || cnt == n - CNT_W'(1));
      hit   = div_wr && div_ch == 3'(c);
      apply = pd && (!act || wrap);
    end
    // A pending ratio only lands on a period boundary (or at once when disabled), so no pulse is cut short.
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        n   <= CNT_W'(DIV_INIT);
        s   <= CNT_W'(DIV_INIT);
        cnt <= '0;
        ck  <= 1'b0;
        tk  <= 1'b0;
        pd  <= 1'b0;
      end else begin
        n   <= apply ? s : n;
        s   <= hit ? div_val : s;
        cnt <= (!act || wrap) ? '0 : cnt + 1'b1;
        ck  <= act && cnt < (n >> 1);
        tk  <= act && cnt == '0;
        pd  <= hit || (pd && !apply);
      end
`ifdef CLK_DIV_ODD50_EN
    logic nq;
    always_ff @(negedge clk or posedge rst)
      if (rst) nq <= 1'b0;
      else nq <= ck;
    assign clk_out[c] = ck | (n[0] & nq);
`else
    assign clk_out[c] = ck;
`endif
    assign tick[c]     = tk;
    assign upd_pend[c] = pd;
  end
endmodule
